// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared character codes and seven-segment pattern table for display producers
package seg_pkg;

    typedef logic [5:0] char_t;

    typedef enum logic [5:0] {
        CH_0 = 6'd0, CH_1, CH_2, CH_3, CH_4, CH_5, CH_6, CH_7, CH_8, CH_9,
        CH_BLANK = 6'd10,
        CH_A = 6'd11, CH_B, CH_C, CH_D, CH_E, CH_F, CH_G, CH_H, CH_I, CH_J,
        CH_K, CH_L, CH_M, CH_N, CH_O, CH_P, CH_Q, CH_R, CH_S, CH_T,
        CH_U, CH_V, CH_W, CH_X, CH_Y, CH_Z
    } char_code_e;

    localparam int          NUM_CODES = 37;
    localparam logic [6:0]  SEG_OFF   = 7'h7F;
    localparam logic [7:0]  AN_OFF    = 8'hFF;

    // Active-low {g,f,e,d,c,b,a}; entries are indexed by character code.
    localparam logic [6:0] SEG_TABLE [NUM_CODES] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000,
        7'b1111111,
        7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001, 7'b0000110,
        7'b0001110, 7'b1000010, 7'b0001001, 7'b1001111, 7'b1100001,
        7'b0001010, 7'b1000111, 7'b1101010, 7'b0101011, 7'b1000000,
        7'b0001100, 7'b0011000, 7'b0101111, 7'b0010010, 7'b0000111,
        7'b1000001, 7'b1100011, 7'b1010101, 7'b0001001, 7'b0010001,
        7'b0100100
    };

endpackage

// File: rtl/seg_char_decode.sv
// rtl/seg_char_decode.sv - combinational character code to active-low cathode pattern
module seg_char_decode
    import seg_pkg::*;
(
    input  char_t      code,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        if (code <= CH_Z) begin
            seg = SEG_TABLE[code];
        end
    end

endmodule

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - 8-digit multiplexed seven-segment scanner with frame snapshot and guard
// Optional display blink is compiled in with SEG_SCAN_BLINK_EN.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int DIGIT_PERIOD = 100000,
    parameter int GUARD_CYCLES = 1000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  char_t      seg_data_in [7:0],
    input  logic       blink_in,
    output logic [6:0] cat_out,
    output logic [7:0] an_out,
    output logic       frame_start_out
);

    localparam int              CNT_W   = $clog2(DIGIT_PERIOD);
    localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(DIGIT_PERIOD - 1);
    localparam logic [CNT_W-1:0] GUARD_C = CNT_W'(GUARD_CYCLES);

    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    char_t            frame [7:0];
    logic             slot_end;
    logic             snap;
    logic [6:0]       cur_seg;
    logic             blank_all;
    logic [7:0]       an_nxt;
    logic [6:0]       cat_nxt;

    assign slot_end = (cnt == LAST_C);
    assign snap     = slot_end && (idx == 3'd7);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cnt <= '0;
            idx <= '0;
        end else if (slot_end) begin
            cnt <= '0;
            idx <= idx + 3'd1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // The displayed frame only changes between the last slot and digit 0.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int k = 0; k < 8; k++) begin
                frame[k] <= CH_BLANK;
            end
        end else if (snap) begin
            for (int k = 0; k < 8; k++) begin
                frame[k] <= seg_data_in[k];
            end
        end
    end

`ifdef SEG_SCAN_BLINK_EN
    localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [FC_W-1:0] frame_cnt;
    logic            phase;
    logic            blink_q;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            frame_cnt <= '0;
            phase     <= 1'b0;
            blink_q   <= 1'b0;
        end else if (snap) begin
            blink_q <= blink_in;
            if (frame_cnt == FC_W'(BLINK_FRAMES - 1)) begin
                frame_cnt <= '0;
                phase     <= ~phase;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    assign blank_all = blink_q & phase;
`else
    logic unused_blink;

    assign unused_blink = blink_in;
    assign blank_all    = 1'b0;
`endif

    seg_char_decode u_decode (
        .code (frame[idx]),
        .seg  (cur_seg)
    );

    // Anodes stay off at the start of each slot so the previous digit's charge bleeds away.
    always_comb begin
        an_nxt  = AN_OFF;
        cat_nxt = SEG_OFF;
        if (cnt >= GUARD_C) begin
            an_nxt  = ~(8'b1 << idx);
            cat_nxt = cur_seg;
        end
        if (blank_all) begin
            an_nxt = AN_OFF;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            an_out          <= AN_OFF;
            cat_out         <= SEG_OFF;
            frame_start_out <= 1'b0;
        end else begin
            an_out          <= an_nxt;
            cat_out         <= cat_nxt;
            frame_start_out <= snap;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb/tb_seg_scan_driver.sv - randomized self-checking bench for seg_scan_driver against a cycle-count model
module tb_seg_scan_driver;

    localparam int P     = 8;
    localparam int G     = 2;
    localparam int BF    = 2;
    localparam int FRAME = 8 * P;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] seg_data [7:0];
    logic       blink = 1'b0;
    logic [6:0] cat;
    logic [7:0] an;
    logic       fs;

    int checks = 0;
    int failures = 0;
    int n = 0;
    int m_frame [8];
    int prev_frame [8];
    int m_snaps = 0;
    int prev_snaps = 0;
    bit m_blink = 1'b0;
    bit prev_blink = 1'b0;

    seg_scan_driver #(
        .DIGIT_PERIOD (P),
        .GUARD_CYCLES (G),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk_in          (clk),
        .rst_n_in        (rst_n),
        .seg_data_in     (seg_data),
        .blink_in        (blink),
        .cat_out         (cat),
        .an_out          (an),
        .frame_start_out (fs)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, n);
        end
    endtask

    function automatic logic [6:0] ref_seg(input int code);
        case (code)
            0: return 7'b1000000;   1: return 7'b1111001;   2: return 7'b0100100;
            3: return 7'b0110000;   4: return 7'b0011001;   5: return 7'b0010010;
            6: return 7'b0000010;   7: return 7'b1111000;   8: return 7'b0000000;
            9: return 7'b0010000;   11: return 7'b0001000;  12: return 7'b0000011;
            13: return 7'b1000110;  14: return 7'b0100001;  15: return 7'b0000110;
            16: return 7'b0001110;  17: return 7'b1000010;  18: return 7'b0001001;
            19: return 7'b1001111;  20: return 7'b1100001;  21: return 7'b0001010;
            22: return 7'b1000111;  23: return 7'b1101010;  24: return 7'b0101011;
            25: return 7'b1000000;  26: return 7'b0001100;  27: return 7'b0011000;
            28: return 7'b0101111;  29: return 7'b0010010;  30: return 7'b0000111;
            31: return 7'b1000001;  32: return 7'b1100011;  33: return 7'b1010101;
            34: return 7'b0001001;  35: return 7'b0010001;  36: return 7'b0100100;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic model_reset();
        n = 0;
        m_snaps = 0;
        m_blink = 1'b0;
        for (int k = 0; k < 8; k++) begin
            m_frame[k] = 10;
        end
    endtask

    // Outputs after edge n reflect the scan position reached after n-1 edges.
    task automatic step();
        int c;
        int id;
        logic [7:0] exp_an;
        logic [6:0] exp_cat;
        @(posedge clk);
        prev_frame = m_frame;
        prev_snaps = m_snaps;
        prev_blink = m_blink;
        n++;
        if (n % FRAME == 0) begin
            for (int k = 0; k < 8; k++) begin
                m_frame[k] = int'(seg_data[k]);
            end
            m_snaps++;
            m_blink = blink;
        end
        @(negedge clk);
        c  = (n - 1) % P;
        id = ((n - 1) / P) % 8;
        if (c < G) begin
            exp_an  = 8'hFF;
            exp_cat = 7'h7F;
        end else begin
            exp_an  = ~(8'(1) << id);
            exp_cat = ref_seg(prev_frame[id]);
        end
`ifdef SEG_SCAN_BLINK_EN
        if (prev_blink && ((prev_snaps / BF) % 2 == 1)) begin
            exp_an = 8'hFF;
        end
`endif
        check("an_out", 32'(an), 32'(exp_an));
        check("cat_out", 32'(cat), 32'(exp_cat));
        check("frame_start", 32'(fs), 32'(n % FRAME == 0));
        check("an_onehot", 32'($countones(~an) <= 1), 32'd1);
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            step();
        end
    endtask

    task automatic check_all_off(input string tag);
        check({tag, "_an"}, 32'(an), 32'h0000_00FF);
        check({tag, "_cat"}, 32'(cat), 32'h0000_007F);
        check({tag, "_fs"}, 32'(fs), 32'd0);
    endtask

    initial begin
        for (int k = 0; k < 8; k++) begin
            seg_data[k] = 6'(k);
        end
        model_reset();
        repeat (3) @(negedge clk);
        check_all_off("reset");
        rst_n = 1'b1;

        // Blank first frame, then the digits 0..7 in scan order.
        run(3 * FRAME);

        // Change digit 0 mid-frame; it must not show until the next snapshot.
        for (int i = 0; i < FRAME && ((n / P) % 8) != 3; i++) begin
            step();
        end
        seg_data[0] = 6'd15;
        run(2 * FRAME);

        // Blank and out-of-range codes.
        seg_data[0] = 6'd0;  seg_data[1] = 6'd10; seg_data[2] = 6'd37; seg_data[3] = 6'd63;
        seg_data[4] = 6'd5;  seg_data[5] = 6'd10; seg_data[6] = 6'd37; seg_data[7] = 6'd63;
        run(2 * FRAME);

        // Random codes changing at random points, random blink requests.
        for (int f = 0; f < 8; f++) begin
            blink = 1'($urandom_range(0, 1));
            for (int i = 0; i < FRAME; i++) begin
                if ($urandom_range(0, 7) == 0) begin
                    seg_data[$urandom_range(0, 7)] = 6'($urandom_range(0, 63));
                end
                if ($urandom_range(0, 31) == 0) begin
                    blink = ~blink;
                end
                step();
            end
        end

        // Sustained blink, then released.
        for (int k = 0; k < 8; k++) begin
            seg_data[k] = 6'($urandom_range(0, 36));
        end
        blink = 1'b1;
        run(8 * FRAME);
        blink = 1'b0;
        run(3 * FRAME);

        // Reset in the middle of a lit slot; outputs must drop without a clock edge.
        for (int i = 0; i < P && (n % P) < G + 1; i++) begin
            step();
        end
        #1;
        rst_n = 1'b0;
        #1;
        check_all_off("async_reset");
        repeat (2) @(negedge clk);
        check_all_off("held_reset");
        model_reset();
        rst_n = 1'b1;
        run(2 * FRAME + 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Downstream consumer of the 8-character display frame built by the game-status display logic.
- Takes eight 6-bit character codes and time-multiplexes them onto the board's 8-digit common-anode seven-segment display.
- Adds a per-slot ghosting guard and a frame snapshot so the display never tears mid-scan.
- Drives the top-level cathode and anode pins directly.

Parameters:
- DIGIT_PERIOD, 100000: clock cycles per digit slot; 1 kHz slot rate at 100 MHz; must be >= 4.
- GUARD_CYCLES, 1000: cycles at the start of each slot with all anodes off; must be < DIGIT_PERIOD.
- BLINK_FRAMES, 64: full 8-digit frames per blink half-period; used only with the optional feature.

Ports:
- clk_in, input, 1: system clock.
- rst_n_in, input, 1: asynchronous active-low reset.
- seg_data_in, input, [5:0] x [7:0] unpacked: character codes; index 0 is the rightmost digit.
- blink_in, input, 1: request display blink; ignored unless the optional feature is compiled in.
- cat_out, output, 7: cathodes {g,f,e,d,c,b,a}, active low.
- an_out, output, 8: anodes, active low; an_out[k] selects digit k.
- frame_start_out, output, 1: one-cycle pulse when a new frame snapshot is taken.

Behaviour:
- Clock and reset: one clock, clk_in. Reset is asynchronous, active-low (rst_n_in).
- Reset values:
  - cnt=0, idx=0, every frame[k]=BLANK (10).
  - an_out=8'hFF, cat_out=7'h7F, frame_start_out=0.
  - The first displayed frame is therefore blank until the first snapshot.
- Prescaler cnt:
  - Counts 0..DIGIT_PERIOD-1, then wraps to 0.
  - The slot-end event is cnt==DIGIT_PERIOD-1.
- Digit index idx (3 bits):
  - Increments on slot-end; 7 wraps to 0.
- Snapshot:
  - On slot-end with idx==7, frame[7:0] <= seg_data_in and frame_start_out pulses high for that one cycle (registered, visible the following cycle).
  - Input changes at any other time do not affect the display until the next snapshot.
- Output registration: outputs are registered from current state, so they lag state by 1 cycle.
  - If cnt < GUARD_CYCLES: next an_out = 8'hFF, next cat_out = 7'h7F.
  - Otherwise: next an_out = ~(8'b1 << idx), next cat_out = decode(frame[idx]).
- Decode rules (active low, gfedcba):
  - Digits: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - 10 (BLANK) = 1111111.
  - Letters 11..36 (A..Z) use the package table; e.g. E(15)=0000110, P(26)=0001100, L(22)=1000111.
  - Codes 37..63 decode as blank.
- Reset mid-scan: all state returns to reset values immediately; outputs go all-off asynchronously.
- Exactly one anode is ever low, never two. Anodes are all high during the guard interval.

Optional Feature:
- Macro: SEG_SCAN_BLINK_EN.
- Compiled in:
  - A frame counter counts snapshots 0..BLINK_FRAMES-1 and toggles a phase bit on wrap; phase resets to 0.
  - While blink_in=1 and phase=1, an_out is forced to 8'hFF (cathodes still decoded).
  - blink_in is sampled at the snapshot, so blinking never starts or stops mid-frame.
- Compiled out: blink_in is unused; behaviour is exactly as described above.

Decomposition:
- Package seg_pkg:
  - Character-code constants 0..36 (BLANK=10, A=11 ... Z=36).
  - typedef char_t = logic [5:0].
  - 37-entry segment-pattern constant table.
  - All display producers share this package.
- Sub-module seg_char_decode: purely combinational char_t to 7-bit cathode pattern. It is instanced once on frame[idx].

Test Plan (DIGIT_PERIOD=8, GUARD_CYCLES=2, BLINK_FRAMES=2):
- Reset: hold rst_n_in=0 mid-scan. Expect an_out=FF and cat_out=7F immediately (asynchronous); after release, the first 64 cycles show blank patterns on each slot.
- Scan order: seg_data_in = {7,6,5,4,3,2,1,0}, run 2 frames.
  - Per slot: an_out=FF for 2 cycles, then FE with cat_out=1000000 for 6 cycles, then FD with 1111001, and so on through 7F with 1111000.
  - frame_start_out pulses once every 64 cycles.
- Snapshot isolation: change seg_data_in[0] to 15 (E) while idx=3. Digit 0 keeps its old pattern until after the next frame_start_out, then shows 0000110.
- Out-of-range and blank: codes 10, 37 and 63 all yield cat_out=1111111 in their slots; anodes still scan normally.
- Invariants (assertion): an_out is always FF or has exactly one bit low; an_out is FF whenever the registered cnt < 2.
- Blink (macro defined, blink_in=1): an_out is FF for 2 whole frames, then scans for 2 frames, alternating. With blink_in=0, scanning is never suppressed.
